// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the BCD nibble type, converter FSM states and digit-count helper.
package seven_seg_pkg;

  typedef logic [3:0] bcd_nib_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_e;

  // A nibble at or above this value would overflow past 9 when doubled.
  localparam bcd_nib_t ADD3_THRESH = 4'd5;

  // Decimal digits needed to show 2^width-1.
  function automatic int min_ndig(input int width);
    longint v;
    int     n;
    v = (longint'(1) << width) - 1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// Ports: clock, reset (async high), valor_in, load -> busy, done, bcd_all.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    valor_in,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd_all
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  b2b_state_e        state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [BW-1:0]     all_q, all_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      all_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      all_q   <= all_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    all_d   = all_q;
    adj     = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= ADD3_THRESH) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = valor_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Whole-word update so the scan never sees a partial result.
        all_d   = bcd_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_all = all_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD conversion plus time-multiplexed digit scan for sete_seg.
// Ports: clock, reset, valor_in, load -> busy, done, bcd_all,
// digit_code (to decoder), digit_sel (active-low one-hot enable).
// Option SEVEN_SEG_ZERO_BLANK_EN: blank leading zero digits.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NDIG     = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    valor_in,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd_all,
  output logic [3:0]          digit_code,
  output logic [NDIG-1:0]     digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (NDIG < min_ndig(WIDTH)) begin : g_ndig_chk
    $error("NDIG too small for WIDTH");
  end

  logic [4*NDIG-1:0] bcd_w;

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_b2b (
    .clock    (clock),
    .reset    (reset),
    .valor_in (valor_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .bcd_all  (bcd_w)
  );

  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NDIG-1:0] sel_q, sel_d;
  bcd_nib_t        code_q, code_d;
`ifdef SEVEN_SEG_ZERO_BLANK_EN
  logic [IW-1:0]   msd;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= ~NDIG'(1);
      code_q  <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
    end
  end

  // Select and code are both registered from the next index, so the
  // enable and the nibble it shows always change on the same edge.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end
    code_d = bcd_w[{idx_d, 2'b00} +: 4];
    sel_d  = ~(NDIG'(1) << idx_d);
`ifdef SEVEN_SEG_ZERO_BLANK_EN
    // Digit 0 is never above msd, so a zero value still shows "0".
    msd = '0;
    for (int i = 1; i < NDIG; i++) begin
      if (bcd_w[4*i +: 4] != 4'd0) begin
        msd = IW'(i);
      end
    end
    if (idx_d > msd) begin
      sel_d = '1;
    end
`endif
  end

  assign bcd_all    = bcd_w;
  assign digit_code = code_q;
  assign digit_sel  = sel_q;

endmodule
